// File: rtl/spi_config_receiver_if.sv
// rtl/spi_config_receiver_if.sv - SPI pin and config-write bundle for spi_config_receiver
//
// Purpose : groups the external SPI pins and the synth config write port
//           into one bundle.
// Modports: slave  - the receiver (takes SPI pins, drives config writes)
//           master - the environment (drives SPI pins, observes writes)
// Signals : i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI   SPI pins towards the receiver
//           o_SPI_MISO                          status echo back to the MCU
//           o_EnvelopeConfigWriteEnable[7:0]    level L1-L4 / rate R1-R4 strobes
//           o_NoteOnConfigWriteEnable[3:0]      note-on byte lane strobes
//           o_ConfigWriteAddr                   target voice-operator
//           o_ConfigWriteData[7:0]              data byte
//           o_FrameActive                       CS asserted (synchronized)
//           o_ErrorCount[7:0]                   only with SPI_CONFIG_ERROR_COUNT_EN

interface spi_config_receiver_if #(
   parameter int VOICE_OP_ID_WIDTH = 6
);
   typedef logic [VOICE_OP_ID_WIDTH-1:0] VoiceOperatorID_t;

   logic             i_SPI_SCK;
   logic             i_SPI_CS_n;
   logic             i_SPI_MOSI;
   logic             o_SPI_MISO;
   logic [7:0]       o_EnvelopeConfigWriteEnable;
   logic [3:0]       o_NoteOnConfigWriteEnable;
   VoiceOperatorID_t o_ConfigWriteAddr;
   logic [7:0]       o_ConfigWriteData;
   logic             o_FrameActive;
`ifdef SPI_CONFIG_ERROR_COUNT_EN
   logic [7:0]       o_ErrorCount;
`endif

   modport slave (
      input  i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI,
      output o_SPI_MISO, o_EnvelopeConfigWriteEnable, o_NoteOnConfigWriteEnable,
             o_ConfigWriteAddr, o_ConfigWriteData, o_FrameActive
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      , output o_ErrorCount
`endif
   );

   modport master (
      output i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI,
      input  o_SPI_MISO, o_EnvelopeConfigWriteEnable, o_NoteOnConfigWriteEnable,
             o_ConfigWriteAddr, o_ConfigWriteData, o_FrameActive
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      , input o_ErrorCount
`endif
   );
endinterface

// File: rtl/spi_config_receiver.sv
// rtl/spi_config_receiver.sv - SPI mode-0 slave decoding 3-byte config frames into write strobes
//
// Purpose : receives {register ID, address, data} frames MSB first from the
//           host MCU and turns each into a single-cycle config write strobe
//           for the envelope attenuator. Several frames may share one CS
//           assertion. MISO echoes a status byte during byte 0.
// Ports   : i_Clock  - system clock
//           i_Reset  - synchronous, active-high reset
//           cfg      - spi_config_receiver_if.slave (SPI pins + config writes)
// Params  : NUM_REG_IDS       - IDs at or above this are rejected
//           VOICE_OP_ID_WIDTH - width of o_ConfigWriteAddr (match the interface)
// Option  : SPI_CONFIG_ERROR_COUNT_EN adds a saturating error counter
//           (rejected IDs + aborted frames) on o_ErrorCount, and puts its low
//           7 bits into the MISO status byte.

module spi_config_receiver #(
   parameter int NUM_REG_IDS       = 12,
   parameter int VOICE_OP_ID_WIDTH = 6
) (
   input logic                  i_Clock,
   input logic                  i_Reset,
   spi_config_receiver_if.slave cfg
);

   typedef enum logic [2:0] {IDLE, REG, ADDR, DATA, COMMIT} state_t;

   state_t state, next_state;

   // SPI pins are asynchronous: two flops each, plus a delay flop on SCK
   // and CS_n for edge detection.
   logic sck_meta, sck_sync, sck_d;
   logic cs_meta, cs_sync, cs_d;
   logic mosi_meta, mosi_sync;

   logic [2:0]                   bit_cnt;
   logic [6:0]                   shift_reg;
   logic [7:0]                   reg_id;
   logic [VOICE_OP_ID_WIDTH-1:0] addr_byte;
   logic [7:0]                   data_byte;
   logic                         last_rejected;
   logic [6:0]                   miso_shift;

   logic [7:0]                   env_q;
   logic [3:0]                   note_q;
   logic [VOICE_OP_ID_WIDTH-1:0] addr_q;
   logic [7:0]                   data_q;
   logic                         miso_q;

   logic       sck_rise, sck_fall, cs_rise, cs_fall;
   logic       in_byte, abort, byte_done, load_status;
   logic [7:0] rx_byte;

   logic       commit, id_reject, rejected_next;
   logic [7:0] env_en_next;
   logic [3:0] note_en_next;
   logic [7:0] status_byte;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sck_meta  <= 1'b0;
         sck_sync  <= 1'b0;
         sck_d     <= 1'b0;
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         cs_d      <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sck_meta  <= cfg.i_SPI_SCK;
         sck_sync  <= sck_meta;
         sck_d     <= sck_sync;
         cs_meta   <= cfg.i_SPI_CS_n;
         cs_sync   <= cs_meta;
         cs_d      <= cs_sync;
         mosi_meta <= cfg.i_SPI_MOSI;
         mosi_sync <= mosi_meta;
      end
   end

   assign sck_rise  = sck_sync & ~sck_d;
   assign sck_fall  = ~sck_sync & sck_d;
   assign cs_rise   = cs_sync & ~cs_d;
   assign cs_fall   = ~cs_sync & cs_d;

   assign in_byte   = (state == REG) || (state == ADDR) || (state == DATA);
   assign abort     = in_byte && cs_rise;
   assign byte_done = in_byte && sck_rise && (bit_cnt == 3'd7) && !cs_rise && !cs_fall;
   assign rx_byte   = {shift_reg, mosi_sync};

   // Status for byte 0 is loaded whenever REG is entered (new CS, restart,
   // or back-to-back after COMMIT).
   assign load_status = (next_state == REG) && ((state != REG) || cs_fall);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= IDLE;
      else         state <= next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (cs_fall) next_state = REG;
         REG, ADDR, DATA: begin
            if (abort)        next_state = IDLE;
            else if (cs_fall) next_state = REG;
            else if (byte_done) begin
               case (state)
                  REG:     next_state = ADDR;
                  ADDR:    next_state = DATA;
                  default: next_state = COMMIT;
               endcase
            end
         end
         // A CS rise coinciding with COMMIT still commits, then idles.
         COMMIT: next_state = cs_sync ? IDLE : REG;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      commit        = (state == COMMIT);
      id_reject     = (32'(reg_id) >= NUM_REG_IDS);
      env_en_next   = 8'd0;
      note_en_next  = 4'd0;
      rejected_next = commit ? id_reject : last_rejected;
      if (commit && !id_reject) begin
         if (reg_id[7:3] == 5'd0)      env_en_next[reg_id[2:0]]  = 1'b1;
         else if (reg_id[7:2] == 6'd2) note_en_next[reg_id[1:0]] = 1'b1;
      end
   end

`ifdef SPI_CONFIG_ERROR_COUNT_EN
   logic [7:0] err_q, err_next;

   always_comb begin
      err_next = err_q;
      if (((commit && id_reject) || abort) && (err_q != 8'hFF)) err_next = err_q + 8'd1;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) err_q <= 8'd0;
      else         err_q <= err_next;
   end

   assign status_byte      = {err_next[6:0], rejected_next};
   assign cfg.o_ErrorCount = err_q;
`else
   assign status_byte = {7'd0, rejected_next};
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         bit_cnt       <= 3'd0;
         shift_reg     <= 7'd0;
         reg_id        <= 8'd0;
         addr_byte     <= '0;
         data_byte     <= 8'd0;
         last_rejected <= 1'b0;
         miso_shift    <= 7'd0;
         env_q         <= 8'd0;
         note_q        <= 4'd0;
         addr_q        <= '0;
         data_q        <= 8'd0;
         miso_q        <= 1'b0;
      end else begin
         env_q  <= env_en_next;
         note_q <= note_en_next;
         if (commit) begin
            last_rejected <= id_reject;
            if (!id_reject) begin
               addr_q <= addr_byte;
               data_q <= data_byte;
            end
         end

         if ((state == IDLE) || commit || cs_fall || cs_rise) bit_cnt <= 3'd0;
         else if (in_byte && sck_rise)                        bit_cnt <= bit_cnt + 3'd1;

         if (in_byte && sck_rise) shift_reg <= rx_byte[6:0];

         if (byte_done) begin
            case (state)
               REG:     reg_id    <= rx_byte;
               ADDR:    addr_byte <= rx_byte[VOICE_OP_ID_WIDTH-1:0];
               default: data_byte <= rx_byte;
            endcase
         end

         // bit_cnt==0 skips the trailing SCK fall of the previous frame's
         // last bit when REG is entered back-to-back.
         if (load_status) begin
            miso_q     <= status_byte[7];
            miso_shift <= status_byte[6:0];
         end else if (state != REG) begin
            miso_q <= 1'b0;
         end else if (sck_fall && (bit_cnt != 3'd0)) begin
            miso_q     <= miso_shift[6];
            miso_shift <= {miso_shift[5:0], 1'b0};
         end
      end
   end

   assign cfg.o_EnvelopeConfigWriteEnable = env_q;
   assign cfg.o_NoteOnConfigWriteEnable   = note_q;
   assign cfg.o_ConfigWriteAddr           = addr_q;
   assign cfg.o_ConfigWriteData           = data_q;
   assign cfg.o_SPI_MISO                  = miso_q;
   assign cfg.o_FrameActive               = ~cs_sync;

endmodule

// File: tb/tb_spi_config_receiver.sv
// tb/tb_spi_config_receiver.sv - directed self-checking bench for spi_config_receiver

module tb_spi_config_receiver;

   logic i_Clock;
   logic i_Reset;
   int   num_checks;
   int   num_fail;

   spi_config_receiver_if #(.VOICE_OP_ID_WIDTH(6)) cfg_if ();

   spi_config_receiver #(.NUM_REG_IDS(12), .VOICE_OP_ID_WIDTH(6)) dut (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .cfg     (cfg_if)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cs_low();
      @(posedge i_Clock); #1;
      cfg_if.i_SPI_CS_n = 1'b0;
      repeat (8) @(posedge i_Clock);
      #1;
   endtask

   task automatic cs_high();
      repeat (4) @(posedge i_Clock);
      #1;
      cfg_if.i_SPI_CS_n = 1'b1;
      repeat (8) @(posedge i_Clock);
      #1;
   endtask

   task automatic spi_bits(input logic [23:0] bits, input int nbits, input int half);
      for (int i = 23; i > 23 - nbits; i--) begin
         cfg_if.i_SPI_MOSI = bits[i];
         repeat (half) @(posedge i_Clock);
         #1;
         cfg_if.i_SPI_SCK = 1'b1;
         repeat (half) @(posedge i_Clock);
         #1;
         cfg_if.i_SPI_SCK = 1'b0;
      end
   endtask

   // Sends one frame; checks the strobe is low 3 edges after the last SCK
   // rise is first sampled, equals the expected value on the 4th, and is
   // low again one cycle later.
   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int half, input logic [7:0] exp_env, input logic [3:0] exp_note,
                             input bit chk_ad, output logic [7:0] status);
      logic [23:0] bits;
      bits   = {b0, b1, b2};
      status = 8'h00;
      for (int i = 23; i >= 0; i--) begin
         cfg_if.i_SPI_MOSI = bits[i];
         repeat (half) @(posedge i_Clock);
         #1;
         if (i >= 16) status[i-16] = cfg_if.o_SPI_MISO;
         cfg_if.i_SPI_SCK = 1'b1;
         if (i == 0) begin
            repeat (4) @(negedge i_Clock);
            check_value("strobe_early", {cfg_if.o_NoteOnConfigWriteEnable, cfg_if.o_EnvelopeConfigWriteEnable}, 32'd0);
            @(negedge i_Clock);
            check_value("env_strobe", cfg_if.o_EnvelopeConfigWriteEnable, exp_env);
            check_value("note_strobe", cfg_if.o_NoteOnConfigWriteEnable, exp_note);
            if (chk_ad) begin
               check_value("addr", cfg_if.o_ConfigWriteAddr, b1);
               check_value("data", cfg_if.o_ConfigWriteData, b2);
            end
            @(negedge i_Clock);
            check_value("strobe_one_cycle", {cfg_if.o_NoteOnConfigWriteEnable, cfg_if.o_EnvelopeConfigWriteEnable}, 32'd0);
            @(posedge i_Clock);
            #1;
         end else begin
            repeat (half) @(posedge i_Clock);
            #1;
         end
         cfg_if.i_SPI_SCK = 1'b0;
      end
   endtask

   task automatic check_quiet(input string tag, input int ncycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < ncycles; c++) begin
         @(negedge i_Clock);
         seen = seen | (|cfg_if.o_EnvelopeConfigWriteEnable) | (|cfg_if.o_NoteOnConfigWriteEnable);
      end
      check_value(tag, seen, 1'b0);
      @(posedge i_Clock);
      #1;
   endtask

   initial begin
      logic [7:0] st;
      num_checks = 0;
      num_fail   = 0;
      cfg_if.i_SPI_SCK  = 1'b0;
      cfg_if.i_SPI_CS_n = 1'b1;
      cfg_if.i_SPI_MOSI = 1'b0;
      i_Reset = 1'b1;
      repeat (3) @(posedge i_Clock);
      @(negedge i_Clock);
      check_value("rst_env", cfg_if.o_EnvelopeConfigWriteEnable, 8'h00);
      check_value("rst_note", cfg_if.o_NoteOnConfigWriteEnable, 4'h0);
      check_value("rst_addr", cfg_if.o_ConfigWriteAddr, 6'h00);
      check_value("rst_data", cfg_if.o_ConfigWriteData, 8'h00);
      check_value("rst_miso", cfg_if.o_SPI_MISO, 1'b0);
      check_value("rst_active", cfg_if.o_FrameActive, 1'b0);
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("rst_errcnt", cfg_if.o_ErrorCount, 8'h00);
`endif
      i_Reset = 1'b0;
      @(posedge i_Clock);
      #1;

      // Envelope rate R2 write
      cs_low();
      check_value("frame_active", cfg_if.o_FrameActive, 1'b1);
      send_frame(8'h05, 8'h2A, 8'h7F, 4, 8'h20, 4'h0, 1'b1, st);
      check_value("status_f1", st, 8'h00);
      cs_high();
      check_value("frame_idle", cfg_if.o_FrameActive, 1'b0);

      // Two frames in one CS assertion
      cs_low();
      send_frame(8'h08, 8'h00, 8'hFF, 4, 8'h00, 4'h1, 1'b1, st);
      check_value("status_b2b1", st, 8'h00);
      send_frame(8'h0B, 8'h01, 8'h80, 4, 8'h00, 4'h8, 1'b1, st);
      check_value("status_b2b2", st, 8'h00);
      cs_high();

      // Rejected ID
      cs_low();
      send_frame(8'h0C, 8'h10, 8'h55, 4, 8'h00, 4'h0, 1'b0, st);
      cs_high();
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("errcnt_reject", cfg_if.o_ErrorCount, 8'h01);
`endif
      cs_low();
      send_frame(8'h00, 8'h03, 8'h11, 4, 8'h01, 4'h0, 1'b1, st);
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("status_after_reject", st, 8'h03);
`else
      check_value("status_after_reject", st, 8'h01);
`endif
      cs_high();

      // Abort after 13 bits
      cs_low();
      spi_bits({8'h02, 8'h04, 8'h66}, 13, 4);
      cs_high();
      check_quiet("abort_no_strobe", 12);
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("errcnt_abort", cfg_if.o_ErrorCount, 8'h02);
`endif
      cs_low();
      send_frame(8'h03, 8'h05, 8'h22, 4, 8'h08, 4'h0, 1'b1, st);
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("status_after_abort", st, 8'h04);
`else
      check_value("status_after_abort", st, 8'h00);
`endif
      cs_high();

      // Reset in the middle of the address byte
      cs_low();
      spi_bits({8'h01, 8'h3C, 8'h00}, 11, 4);
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b1;
      @(posedge i_Clock);
      @(negedge i_Clock);
      check_value("mid_rst_env", cfg_if.o_EnvelopeConfigWriteEnable, 8'h00);
      check_value("mid_rst_note", cfg_if.o_NoteOnConfigWriteEnable, 4'h0);
      check_value("mid_rst_addr", cfg_if.o_ConfigWriteAddr, 6'h00);
      check_value("mid_rst_data", cfg_if.o_ConfigWriteData, 8'h00);
      check_value("mid_rst_miso", cfg_if.o_SPI_MISO, 1'b0);
      check_value("mid_rst_active", cfg_if.o_FrameActive, 1'b0);
`ifdef SPI_CONFIG_ERROR_COUNT_EN
      check_value("mid_rst_errcnt", cfg_if.o_ErrorCount, 8'h00);
`endif
      i_Reset = 1'b0;
      cfg_if.i_SPI_CS_n = 1'b1;
      check_quiet("mid_rst_no_strobe", 10);
      cs_low();
      send_frame(8'h07, 8'h3F, 8'hC3, 4, 8'h80, 4'h0, 1'b1, st);
      check_value("status_after_rst", st, 8'h00);
      cs_high();

`ifdef SPI_CONFIG_ERROR_COUNT_EN
      // Saturation of the error counter
      cs_low();
      for (int k = 0; k < 300; k++) send_frame(8'h0C, 8'h00, 8'h00, 3, 8'h00, 4'h0, 1'b0, st);
      cs_high();
      check_value("errcnt_saturate", cfg_if.o_ErrorCount, 8'hFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
